rgb_mem_arbiter: RTL

//  Shares the three single-port 128x128 image SRAMs (R, G, B planes; 16384 x 8b each) between two masters.

---
 rtl/demosaic_pkg.sv | 29 ++
 rtl/rgb_mem_arbiter_rd_lat_pipe.sv | 41 ++++
 rtl/rgb_mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/demosaic_pkg.sv
// Shared constants and types for the RGB image-plane memory subsystem.
// Packed plane buses are ordered {r,g,b}; the plane index constants select lanes.
package demosaic_pkg;

    localparam int IMG_W   = 128;
    localparam int ADDR_W  = 2 * $clog2(IMG_W);
    localparam int PIX_W   = 8;
    localparam int NPLANE  = 3;
    localparam int PLANE_R = 2;
    localparam int PLANE_G = 1;
    localparam int PLANE_B = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    function automatic logic [ADDR_W-1:0] plane_addr(input logic [NPLANE*ADDR_W-1:0] bus,
                                                     input int plane);
        return bus[plane*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [PIX_W-1:0] plane_pix(input logic [NPLANE*PIX_W-1:0] bus,
                                                   input int plane);
        return bus[plane*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/rgb_mem_arbiter_rd_lat_pipe.sv
// Read-return tracker: shifts {valid,id} of each granted read along with the
// SRAM read latency so the data can be tagged back to its master.
module rd_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic push_valid,
    input  logic push_id,
    output logic pop_valid,
    output logic pop_id
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] id_q, id_d;

    always_comb begin
        valid_d    = valid_q;
        id_d       = id_q;
        valid_d[0] = push_valid;
        id_d[0]    = push_id;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            id_d[i]    = id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign pop_valid = valid_q[DEPTH-1];
    assign pop_id    = id_q[DEPTH-1];

endmodule

// File: rtl/rgb_mem_arbiter.sv
// Two-master arbiter for the R/G/B image SRAMs: round-robin with burst lock,
// a starvation cap on locked bursts, and tagged read-data return.
//
// state | meaning
// IDLE  | no burst owner; round-robin between requesters, rr_ptr favoured
// OWN0  | master 0 holds a locked burst, master 1 stalled
// OWN1  | master 1 holds a locked burst, master 0 stalled
module rgb_mem_arbiter
    import demosaic_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     m0_req,
    input  logic                     m0_lock,
    input  logic [NPLANE-1:0]        m0_wr,
    input  logic [NPLANE*ADDR_W-1:0] m0_addr,
    input  logic [NPLANE*PIX_W-1:0]  m0_wdata,
    output logic                     m0_gnt,
    output logic                     m0_rvalid,
    output logic [NPLANE*PIX_W-1:0]  m0_rdata,

    input  logic                     m1_req,
    input  logic                     m1_lock,
    input  logic [NPLANE-1:0]        m1_wr,
    input  logic [NPLANE*ADDR_W-1:0] m1_addr,
    input  logic [NPLANE*PIX_W-1:0]  m1_wdata,
    output logic                     m1_gnt,
    output logic                     m1_rvalid,
    output logic [NPLANE*PIX_W-1:0]  m1_rdata,

    output logic                     lock_abort,

    output logic                     wr_r,
    output logic                     wr_g,
    output logic                     wr_b,
    output logic [ADDR_W-1:0]        addr_r,
    output logic [ADDR_W-1:0]        addr_g,
    output logic [ADDR_W-1:0]        addr_b,
    output logic [PIX_W-1:0]         wdata_r,
    output logic [PIX_W-1:0]         wdata_g,
    output logic [PIX_W-1:0]         wdata_b,
    input  logic [PIX_W-1:0]         rdata_r,
    input  logic [PIX_W-1:0]         rdata_g,
    input  logic [PIX_W-1:0]         rdata_b
);

    localparam int CNT_W = $clog2(MAX_LOCK);

    arb_state_t        state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  lock_left_q, lock_left_d;

    logic [1:0]                 req, lock, gnt;
    logic                       win, own, abort;
    logic [NPLANE-1:0]          bus_wr;
    logic [NPLANE*ADDR_W-1:0]   bus_addr;
    logic [NPLANE*PIX_W-1:0]    bus_wdata;
    logic                       pop_valid, pop_id;

    assign req  = {m1_req, m0_req};
    assign lock = {m1_lock, m0_lock};

    // lock_left counts down the grants a burst may still take before the cap
    // bites; zero means the current grant is the MAX_LOCK-th of the burst.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_left_d = lock_left_q;
        gnt         = 2'b00;
        win         = 1'b0;
        own         = 1'b0;
        abort       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req[0] && (!req[1] || !rr_ptr_q)) begin
                    gnt = 2'b01;
                end else if (req[1]) begin
                    gnt = 2'b10;
                end
                if (gnt != 2'b00) begin
                    win      = gnt[1];
                    rr_ptr_d = ~win;
                    if (lock[win]) begin
                        state_d     = win ? OWN1 : OWN0;
                        lock_left_d = CNT_W'(MAX_LOCK - 2);
                    end
                end
            end
            OWN0, OWN1: begin
                own      = (state_q == OWN1);
                gnt[own] = req[own];
                if (req[own] && lock[own]) begin
                    if (lock_left_q == '0) begin
                        if (req[~own]) begin
                            abort    = 1'b1;
                            state_d  = IDLE;
                            rr_ptr_d = ~own;
                        end
                    end else begin
                        lock_left_d = lock_left_q - CNT_W'(1);
                    end
                end else begin
                    state_d     = IDLE;
                    rr_ptr_d    = ~own;
                    lock_left_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            lock_left_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_left_q <= lock_left_d;
        end
    end

    always_comb begin
        bus_wr    = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (gnt[0]) begin
            bus_wr    = m0_wr;
            bus_addr  = m0_addr;
            bus_wdata = m0_wdata;
        end else if (gnt[1]) begin
            bus_wr    = m1_wr;
            bus_addr  = m1_addr;
            bus_wdata = m1_wdata;
        end
    end

    assign wr_r    = bus_wr[PLANE_R];
    assign wr_g    = bus_wr[PLANE_G];
    assign wr_b    = bus_wr[PLANE_B];
    assign addr_r  = plane_addr(bus_addr, PLANE_R);
    assign addr_g  = plane_addr(bus_addr, PLANE_G);
    assign addr_b  = plane_addr(bus_addr, PLANE_B);
    assign wdata_r = plane_pix(bus_wdata, PLANE_R);
    assign wdata_g = plane_pix(bus_wdata, PLANE_G);
    assign wdata_b = plane_pix(bus_wdata, PLANE_B);

    assign m0_gnt     = gnt[0];
    assign m1_gnt     = gnt[1];
    assign lock_abort = abort;

    rd_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clk        (clk),
        .clear      (reset),
        .push_valid ((gnt != 2'b00) && (bus_wr != 3'b111)),
        .push_id    (gnt[1]),
        .pop_valid  (pop_valid),
        .pop_id     (pop_id)
    );

    // Read data is shared; rvalid alone tells a master the bytes are its own.
    assign m0_rvalid = pop_valid & ~pop_id;
    assign m1_rvalid = pop_valid & pop_id;
    assign m0_rdata  = {rdata_r, rdata_g, rdata_b};
    assign m1_rdata  = {rdata_r, rdata_g, rdata_b};

endmodule
